// File: rtl/bp_pkg.sv
// Shared types and constants for the branch target buffer: entry layout,
// 2-bit direction counter encodings and the tag extraction helper.
package bp_pkg;

    localparam int PC_W = 32;

    localparam logic [1:0] STRONG_NT = 2'b00;
    localparam logic [1:0] WEAK_NT   = 2'b01;
    localparam logic [1:0] WEAK_T    = 2'b10;
    localparam logic [1:0] STRONG_T  = 2'b11;

    // Tag is kept full-width so the package stays independent of INDEX_BITS;
    // the bits above pc[31:INDEX_BITS+2] are always zero.
    typedef struct packed {
        logic            valid;
        logic [PC_W-1:0] tag;
        logic [PC_W-1:0] target;
        logic [1:0]      ctr;
    } bp_entry_t;

    function automatic logic [PC_W-1:0] pc_tag(input logic [PC_W-1:0] pc,
                                               input int index_bits);
        return pc >> (index_bits + 2);
    endfunction

endpackage

// File: rtl/bp_sat_ctr.sv
// 2-bit saturating up/down counter step, purely combinational.
module bp_sat_ctr
    import bp_pkg::*;
(
    input  logic [1:0] ctr_i,
    input  logic       inc_i,
    output logic [1:0] ctr_o
);

    always_comb begin
        ctr_o = ctr_i;
        if (inc_i) begin
            if (ctr_i != STRONG_T) ctr_o = ctr_i + 2'd1;
        end else begin
            if (ctr_i != STRONG_NT) ctr_o = ctr_i - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters: zero-latency lookup for
// fetch, training and mispredict/redirect from EX, saturating perf counters.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int INDEX_BITS = 4,
    parameter int PERF_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [PC_W-1:0]   f_pc,
    output logic              pred_taken,
    output logic [PC_W-1:0]   pred_target,
    input  logic              ex_valid,
    input  logic              ex_stall,
    input  logic [PC_W-1:0]   ex_pc,
    input  logic              ex_taken,
    input  logic [PC_W-1:0]   ex_target,
    input  logic              ex_pred_taken,
    input  logic [PC_W-1:0]   ex_pred_target,
    output logic              mispredict,
    output logic [PC_W-1:0]   redirect_pc,
    output logic [PERF_W-1:0] perf_total,
    output logic [PERF_W-1:0] perf_taken,
    output logic [PERF_W-1:0] perf_mispredict
);

    localparam int ENTRIES = 1 << INDEX_BITS;

    bp_entry_t entry_q [ENTRIES];
    bp_entry_t entry_d;
    bp_entry_t f_entry;
    bp_entry_t ex_entry;

    logic [INDEX_BITS-1:0] f_idx;
    logic [INDEX_BITS-1:0] ex_idx;
    logic                  f_hit;
    logic                  ex_hit;
    logic                  fire;
    logic [1:0]            ctr_next;
    logic [ENTRIES-1:0]    we;

    logic [PERF_W-1:0] perf_total_q;
    logic [PERF_W-1:0] perf_taken_q;
    logic [PERF_W-1:0] perf_mispredict_q;

    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v,
                                                  input logic en);
        return (en && (v != '1)) ? v + 1'b1 : v;
    endfunction

    // Fetch-side lookup reads the table state before any same-cycle update.
    assign f_idx       = f_pc[INDEX_BITS+1:2];
    assign f_entry     = entry_q[f_idx];
    assign f_hit       = f_entry.valid && (f_entry.tag == pc_tag(f_pc, INDEX_BITS));
    assign pred_taken  = f_hit && f_entry.ctr[1];
    assign pred_target = pred_taken ? f_entry.target : f_pc + 32'd4;

    assign fire        = ex_valid && !ex_stall;
    assign mispredict  = fire && ((ex_taken != ex_pred_taken) ||
                         (ex_taken && ex_pred_taken && (ex_target != ex_pred_target)));
    assign redirect_pc = ex_taken ? ex_target : ex_pc + 32'd4;

    assign ex_idx   = ex_pc[INDEX_BITS+1:2];
    assign ex_entry = entry_q[ex_idx];
    assign ex_hit   = ex_entry.valid && (ex_entry.tag == pc_tag(ex_pc, INDEX_BITS));

    bp_sat_ctr u_sat_ctr (
        .ctr_i (ex_entry.ctr),
        .inc_i (ex_taken),
        .ctr_o (ctr_next)
    );

    always_comb begin
        entry_d = ex_entry;
        if (ex_hit) begin
            entry_d.ctr = ctr_next;
            if (ex_taken) entry_d.target = ex_target;
        end else if (ex_taken) begin
            entry_d.valid  = 1'b1;
            entry_d.tag    = pc_tag(ex_pc, INDEX_BITS);
            entry_d.target = ex_target;
            entry_d.ctr    = WEAK_T;
        end
    end

    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_we
        assign we[gi] = fire && (ex_idx == INDEX_BITS'(gi));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                entry_q[i].valid  <= 1'b0;
                entry_q[i].tag    <= '0;
                entry_q[i].target <= '0;
                entry_q[i].ctr    <= WEAK_NT;
            end
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (we[i]) entry_q[i] <= entry_d;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_total_q      <= '0;
            perf_taken_q      <= '0;
            perf_mispredict_q <= '0;
        end else if (fire) begin
            perf_total_q      <= sat_inc(perf_total_q, 1'b1);
            perf_taken_q      <= sat_inc(perf_taken_q, ex_taken);
            perf_mispredict_q <= sat_inc(perf_mispredict_q, mispredict);
        end
    end

    assign perf_total      = perf_total_q;
    assign perf_taken      = perf_taken_q;
    assign perf_mispredict = perf_mispredict_q;

endmodule
